hazard_scoreboard_unit: RTL

//  Next-generation pipeline hazard unit for the 5-stage RISC-V core, now with a multi-cycle FP unit.

---
 rtl/hazard_scoreboard_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: M/W forwarding, load-use stall and a countdown
// scoreboard covering FP RAW, WAW and FP-unit structural hazards.
module hazard_scoreboard_unit #(
    parameter int REG_AW       = 5,
    parameter int FP_LAT       = 4,
    parameter int LAT_W        = 3,
    parameter int FP_PIPELINED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              IsFpD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              IsFpE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              FpBusy
);

    localparam int NREGS = 2 ** REG_AW;
    localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(FP_LAT);

    logic [LAT_W-1:0] cnt [NREGS];

    // Entry 0 stays zero so x0 can never look busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (IsFpE && RdE == REG_AW'(i))
                    cnt[i] <= LOAD_VAL;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        FpBusy = 1'b0;
        for (int i = 1; i < NREGS; i++)
            if (cnt[i] != '0) FpBusy = 1'b1;
    end

    always_comb begin
        ForwardAE = 2'b00;
        if (Rs1E != '0 && Rs1E == RdM && RegWriteM)
            ForwardAE = 2'b10;
        else if (Rs1E != '0 && Rs1E == RdW && RegWriteW)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (Rs2E != '0 && Rs2E == RdM && RegWriteM)
            ForwardBE = 2'b10;
        else if (Rs2E != '0 && Rs2E == RdW && RegWriteW)
            ForwardBE = 2'b01;
    end

    logic s1Nz, s2Nz, s1MatchE, s2MatchE, eDst;
    logic lwHz, fpEHz, rawHz, wawHz, strHz, stall;

    assign s1Nz     = Rs1D != '0;
    assign s2Nz     = Rs2D != '0;
    assign eDst     = RdE != '0;
    assign s1MatchE = s1Nz && Rs1D == RdE;
    assign s2MatchE = s2Nz && Rs2D == RdE;

    assign lwHz  = ResultSrcE == 2'b01 && eDst
                 && (s1MatchE || s2MatchE);
    assign fpEHz = IsFpE && eDst && (s1MatchE || s2MatchE);

    // At cnt==1 the result is forwardable, so sources only wait while cnt>=2.
    assign rawHz = (s1Nz && cnt[Rs1D] > LAT_W'(1))
                 || (s2Nz && cnt[Rs2D] > LAT_W'(1));

    assign wawHz = RegWriteD && RdD != '0
                 && (cnt[RdD] != '0 || (IsFpE && RdD == RdE));

    assign strHz = (FP_PIPELINED == 0) && IsFpD && (FpBusy || IsFpE);

    assign stall = lwHz | fpEHz | rawHz | wawHz | strHz;

    assign FlushD = PCSrcE;
    assign FlushE = stall | PCSrcE;
    assign StallF = stall & ~PCSrcE;
    assign StallD = stall & ~PCSrcE;

endmodule
